nn_layer_sequencer: RTL and testbench
=====================================

Name: nn_layer_sequencer

Overview:
Top-level sequencer for the two-layer MNIST datapath. It accepts a run command from the picoRV32 bus side and takes image words over a valid/ready handshake. It drives the layer-1 systolic array (image, counter1, start1), then the ReLU/layer-2 pass (counter2, start2), waits for pipeline drain, and signals completion. It replaces the free-running control path: counter1/counter2 also address the weight/bias memory.

Parameters:
N_IN, 784, number of image words accepted per inference (layer-1 steps)
N_HID, 32, hidden neurons (layer-2 steps, counter2 range 0..N_HID-1)
N_OUT, 10, output neurons (used only by the optional argmax)
PIPE_LAT, 2, drain cycles after the last start1/start2 before the next phase

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
cmd_start  in  1  begin an inference (level-sampled in IDLE/DONE)
cmd_abort  in  1  synchronous abort to IDLE from any state
img_valid  in  1  image word valid
img_data  in  32  image word
img_ready  out  1  sequencer accepts image word this cycle
image  out  32  registered image word to systolic1
counter1  out  32  layer-1 step index / weight address
counter2  out  32  layer-2 step index / weight address and relu select
start1  out  1  advance systolic1 one step
start2  out  1  advance systolic2 one step
stop1  out  1  layer 1 complete
stop2  out  1  layer 2 complete
busy  out  1  high in any state other than IDLE/DONE
done  out  1  inference complete, results stable
result_sel  out  4  result mux select (argmax only)
result_data  in  32  selected result word (argmax only)
class_out  out  4  predicted digit (argmax only)

Behaviour:
- Reset (async): state IDLE; all outputs 0, including image, counters and class_out.
- States: IDLE, L1_FEED, L1_DRAIN, L2_FEED, L2_DRAIN, [ARGMAX], DONE.
- IDLE: img_ready=0. cmd_start=1 → L1_FEED; counter1, counter2 and the internal drain counter cleared; stop1=stop2=0.
- L1_FEED: img_ready=1. When img_valid&img_ready at edge t, then after edge t: image=img_data, start1=1 for exactly one cycle, counter1=k (k = 0-based index of that word). With no handshake, start1=0 and image/counter1 hold (the array stalls). After the N_IN-th handshake, img_ready drops in the same edge and the state becomes L1_DRAIN.
- L1_DRAIN: start1=0 for PIPE_LAT cycles, then stop1=1 (held until the next run or abort) → L2_FEED.
- L2_FEED: no stall. start2=1 for N_HID consecutive cycles with counter2=0,1,…,N_HID-1. Then → L2_DRAIN.
- L2_DRAIN: PIPE_LAT cycles, then stop2=1 → ARGMAX if compiled in, else DONE.
- DONE: done=1, busy=0. counter1 holds N_IN-1 and counter2 holds N_HID-1. cmd_start=1 → L1_FEED, with counters and stops cleared as in IDLE.
- cmd_start while busy: ignored.
- cmd_abort has priority over all other transitions, including a simultaneous cmd_start. It forces IDLE with the reset values on the next edge; systolic accumulators are not cleared by this block.
- Counters are 32-bit unsigned and never wrap within a run. A step-count comparison reaching its limit is the only phase exit.
- Reset mid-operation: immediate IDLE; any partial image is discarded.

Optional Feature:
Macro ARGMAX_EN.
- Defined: after L2_DRAIN the ARGMAX state runs for N_OUT+1 cycles. result_sel steps 0..N_OUT-1, and result_data is sampled one cycle after each select. Values are compared as signed 32-bit. A strictly greater value replaces the current best, so on a tie the lowest index wins. class_out is registered and valid when done rises; it holds until the next run or abort.
- Undefined: the ARGMAX state is absent, result_sel=0 and class_out=0 constant, and result_data is unused.

Test Plan:
All tests use N_IN=4, N_HID=3, PIPE_LAT=2.
- Reset: assert reset mid-L1_FEED after 2 words → next sample shows all outputs 0, state IDLE, img_ready=0.
- Nominal run: cmd_start, then 4 back-to-back words 0xA,0xB,0xC,0xD → start1 high 4 cycles with (image,counter1)=(A,0),(B,1),(C,2),(D,3). stop1 rises 2 cycles later. start2 follows for 3 cycles with counter2=0,1,2. stop2 and done rise after 2 more cycles (no ARGMAX_EN).
- Backpressure: img_valid toggles 1,0,0,1,1,0,1 → exactly 4 start1 pulses, only on cycles after handshakes; counter1 holds during gaps.
- Command rules: cmd_start while busy → no effect on counters. cmd_start and cmd_abort together in L2_FEED → IDLE.
- Restart from DONE: cmd_start → stop1/stop2/done clear, and counter1 restarts at 0 on the first new word.
- ARGMAX_EN: results {5,-3,9,9,0,1,2,3,4,-1} → class_out=2 at done.

Source files
------------

// File: rtl/nn_layer_sequencer_if.sv
// Host-side command and image-stream handshake for nn_layer_sequencer.
// The master drives commands and image words; the slave (sequencer) returns img_ready.
interface nn_layer_sequencer_if;
  logic        cmd_start;
  logic        cmd_abort;
  logic        img_valid;
  logic [31:0] img_data;
  logic        img_ready;

  modport master (output cmd_start, cmd_abort, img_valid, img_data, input img_ready);
  modport slave  (input cmd_start, cmd_abort, img_valid, img_data, output img_ready);
endinterface

// File: rtl/nn_layer_sequencer.sv
// Two-layer MNIST control sequencer: L1 feed/drain, L2 feed/drain, optional argmax, done.
// Optional argmax over N_OUT results is compiled in with macro ARGMAX_EN.
module nn_layer_sequencer #(
  parameter int N_IN     = 784,
  parameter int N_HID    = 32,
  parameter int N_OUT    = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  nn_layer_sequencer_if.slave  host,
  output logic [31:0]          image,
  output logic [31:0]          counter1,
  output logic [31:0]          counter2,
  output logic                 start1,
  output logic                 start2,
  output logic                 stop1,
  output logic                 stop2,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           result_sel,
  input  logic [31:0]          result_data,
  output logic [3:0]           class_out
);

  typedef enum logic [2:0] {
    IDLE, L1_FEED, L1_DRAIN, L2_FEED, L2_DRAIN,
`ifdef ARGMAX_EN
    ARGMAX,
`endif
    DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt;   // shared step/drain counter, cleared on every state change
  logic        hs;

  assign host.img_ready = (state == L1_FEED);
  assign hs             = host.img_valid & host.img_ready;
  assign busy           = (state != IDLE) && (state != DONE);
  assign done           = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (host.cmd_start) state_nxt = L1_FEED;
      L1_FEED:    if (hs && cnt == 32'(N_IN - 1)) state_nxt = L1_DRAIN;
      L1_DRAIN:   if (cnt == 32'(PIPE_LAT - 1)) state_nxt = L2_FEED;
      L2_FEED:    if (cnt == 32'(N_HID - 1)) state_nxt = L2_DRAIN;
`ifdef ARGMAX_EN
      L2_DRAIN:   if (cnt == 32'(PIPE_LAT - 1)) state_nxt = ARGMAX;
      ARGMAX:     if (cnt == 32'(N_OUT)) state_nxt = DONE;
`else
      L2_DRAIN:   if (cnt == 32'(PIPE_LAT - 1)) state_nxt = DONE;
`endif
      default:    state_nxt = IDLE;
    endcase
    // Abort outranks every other transition, including a concurrent start.
    if (host.cmd_abort) state_nxt = IDLE;
  end

`ifdef ARGMAX_EN
  logic signed [31:0] best_val;
  logic        [3:0]  best_idx;
  logic signed [31:0] samp;
  logic        [3:0]  samp_idx, win_idx;
  logic               take;
  logic        [3:0]  sel_q, class_q;

  // Cycle cnt of ARGMAX sees the result selected in cycle cnt-1; first sample seeds the best.
  assign samp     = signed'(result_data);
  assign samp_idx = 4'(cnt - 32'd1);
  assign take     = (cnt == 32'd1) || (samp > best_val);
  assign win_idx  = take ? samp_idx : best_idx;

  always_ff @(posedge clk) begin
    if (state == ARGMAX && cnt != 32'd0 && take) begin
      best_val <= samp;
      best_idx <= samp_idx;
    end
  end

  assign result_sel = sel_q;
  assign class_out  = class_q;
`else
  logic unused_result;
  assign unused_result = ^result_data;
  assign result_sel    = 4'd0;
  assign class_out     = 4'd0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset || host.cmd_abort) begin
      image    <= '0;
      counter1 <= '0;
      counter2 <= '0;
      start1   <= 1'b0;
      start2   <= 1'b0;
      stop1    <= 1'b0;
      stop2    <= 1'b0;
      cnt      <= '0;
`ifdef ARGMAX_EN
      sel_q    <= '0;
      class_q  <= '0;
`endif
    end else begin
      start1 <= 1'b0;
      start2 <= 1'b0;
      case (state)
        IDLE, DONE: if (host.cmd_start) begin
          counter1 <= '0;
          counter2 <= '0;
          stop1    <= 1'b0;
          stop2    <= 1'b0;
`ifdef ARGMAX_EN
          sel_q    <= '0;
          class_q  <= '0;
`endif
        end
        L1_FEED: if (hs) begin
          image    <= host.img_data;
          counter1 <= cnt;
          start1   <= 1'b1;
        end
        L1_DRAIN: if (state_nxt != L1_DRAIN) stop1 <= 1'b1;
        L2_FEED: begin
          start2   <= 1'b1;
          counter2 <= cnt;
        end
        L2_DRAIN: if (state_nxt != L2_DRAIN) stop2 <= 1'b1;
`ifdef ARGMAX_EN
        ARGMAX: begin
          if (cnt < 32'(N_OUT - 1)) sel_q <= sel_q + 4'd1;
          if (cnt == 32'(N_OUT))    class_q <= win_idx;
        end
`endif
        default: ;
      endcase
      // Image phase only advances on a handshake so the array stalls with the host.
      if (state_nxt != state)                cnt <= '0;
      else if (busy && (state != L1_FEED || hs)) cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer with N_IN=4, N_HID=3, PIPE_LAT=2.
// Build with ARGMAX_EN defined to also exercise the argmax result.
module tb_nn_layer_sequencer;
  localparam int N_IN     = 4;
  localparam int N_HID    = 3;
  localparam int N_OUT    = 10;
  localparam int PIPE_LAT = 2;
`ifdef ARGMAX_EN
  localparam logic [3:0] EXP_CLASS   = 4'd2;
  localparam int         EXP_ARG_CYC = N_OUT + 1;
`else
  localparam logic [3:0] EXP_CLASS   = 4'd0;
  localparam int         EXP_ARG_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] image, counter1, counter2, result_data;
  logic        start1, start2, stop1, stop2, busy, done;
  logic [3:0]  result_sel, class_out;
  logic [31:0] res_tab [16];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  nn_layer_sequencer_if hif ();

  nn_layer_sequencer #(
    .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .reset(reset), .host(hif.slave),
    .image(image), .counter1(counter1), .counter2(counter2),
    .start1(start1), .start2(start2), .stop1(stop1), .stop2(stop2),
    .busy(busy), .done(done), .result_sel(result_sel),
    .result_data(result_data), .class_out(class_out)
  );

  // Result memory with one cycle of read latency behind result_sel.
  always @(posedge clk) result_data <= res_tab[result_sel];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [6:0] bp_pat;
    int         cyc;
    int         nhs;
    int         npulse;

    hif.cmd_start = 1'b0;
    hif.cmd_abort = 1'b0;
    hif.img_valid = 1'b0;
    hif.img_data  = '0;
    for (int i = 0; i < 16; i++) res_tab[i] = '0;
    res_tab[0] = 32'd5;  res_tab[1] = 32'hFFFF_FFFD; res_tab[2] = 32'd9;
    res_tab[3] = 32'd9;  res_tab[4] = 32'd0;         res_tab[5] = 32'd1;
    res_tab[6] = 32'd2;  res_tab[7] = 32'd3;         res_tab[8] = 32'd4;
    res_tab[9] = 32'hFFFF_FFFF;

    step(); step();
    reset = 1'b0;
    step();
    check("rst_image", image, 0);
    check("rst_cnt1", counter1, 0);
    check("rst_cnt2", counter2, 0);
    check("rst_starts", {start1, start2, stop1, stop2}, 0);
    check("rst_ready", hif.img_ready, 0);
    check("rst_busy_done", {busy, done}, 0);
    check("rst_class", class_out, 0);
    check("rst_sel", result_sel, 0);

    // Nominal run, back-to-back words
    hif.cmd_start = 1'b1;
    step();
    hif.cmd_start = 1'b0;
    check("nom_busy", busy, 1);
    check("nom_ready", hif.img_ready, 1);
    check("nom_start1_idle", start1, 0);
    for (int k = 0; k < N_IN; k++) begin
      hif.img_valid = 1'b1;
      hif.img_data  = 32'hA + 32'(k);
      step();
      check("nom_start1", start1, 1);
      check("nom_image", image, 32'hA + 32'(k));
      check("nom_cnt1", counter1, 32'(k));
    end
    hif.img_valid = 1'b0;
    check("nom_ready_drop", hif.img_ready, 0);
    step();
    check("nom_drain1", {start1, stop1}, 2'b00);
    step();
    check("nom_stop1", stop1, 1);
    check("nom_start2_pre", start2, 0);
    for (int j = 0; j < N_HID; j++) begin
      step();
      check("nom_start2", start2, 1);
      check("nom_cnt2", counter2, 32'(j));
    end
    step();
    check("nom_drain2", {start2, stop2}, 2'b00);
    step();
    check("nom_stop2", stop2, 1);
    cyc = 0;
    while (!done && cyc < 30) begin
      step();
      cyc++;
    end
    check("nom_done_lat", 32'(cyc), 32'(EXP_ARG_CYC));
    check("nom_done", {done, busy}, 2'b10);
    check("nom_cnt1_hold", counter1, 32'(N_IN - 1));
    check("nom_cnt2_hold", counter2, 32'(N_HID - 1));
    check("nom_class", class_out, EXP_CLASS);

    // Restart from DONE, then backpressure on the image stream
    hif.cmd_start = 1'b1;
    step();
    hif.cmd_start = 1'b0;
    check("rs_clear", {stop1, stop2, done}, 3'b000);
    check("rs_busy", busy, 1);
    check("rs_cnt1", counter1, 0);
    check("rs_class", class_out, 0);
    bp_pat = 7'b1011001;  // bit 0 first: 1,0,0,1,1,0,1
    nhs = 0;
    npulse = 0;
    for (int i = 0; i < 7; i++) begin
      hif.img_valid = bp_pat[i];
      hif.img_data  = 32'h10 + 32'(i);
      step();
      if (bp_pat[i]) nhs++;
      if (start1) npulse++;
      check("bp_start1", start1, bp_pat[i]);
      check("bp_cnt1", counter1, (nhs == 0) ? 32'd0 : 32'(nhs - 1));
    end
    hif.img_valid = 1'b0;
    check("bp_pulses", 32'(npulse), 32'd4);
    check("bp_last_image", image, 32'h16);
    check("bp_ready_drop", hif.img_ready, 0);

    // cmd_start while busy is ignored
    hif.cmd_start = 1'b1;
    step();
    hif.cmd_start = 1'b0;
    check("busy_start_cnt1", counter1, 32'd3);
    check("busy_start_stop1", stop1, 0);
    step();
    check("busy_start_stop1_rise", stop1, 1);
    step();
    check("busy_start_l2", {start2, counter2}, {1'b1, 32'd0});

    // Start and abort together in L2_FEED -> IDLE
    hif.cmd_start = 1'b1;
    hif.cmd_abort = 1'b1;
    step();
    hif.cmd_start = 1'b0;
    hif.cmd_abort = 1'b0;
    check("abort_busy", {busy, done}, 2'b00);
    check("abort_outs", {start1, start2, stop1, stop2}, 0);
    check("abort_cnt1", counter1, 0);
    check("abort_image", image, 0);
    step();
    check("abort_stays_idle", {busy, start2, hif.img_ready}, 0);

    // Asynchronous reset mid-L1_FEED after two words
    hif.cmd_start = 1'b1;
    step();
    hif.cmd_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      hif.img_valid = 1'b1;
      hif.img_data  = 32'h55 + 32'(k);
      step();
    end
    hif.img_valid = 1'b0;
    check("mid_cnt1_before", counter1, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_image", image, 0);
    check("mid_rst_cnt1", counter1, 0);
    check("mid_rst_ctrl", {start1, start2, stop1, stop2, busy, done}, 0);
    check("mid_rst_ready", hif.img_ready, 0);
    step();
    reset = 1'b0;
    step();
    check("mid_rst_idle", {busy, hif.img_ready}, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
